data_ram_ctrl: RTL and testbench
================================

Name: data_ram_ctrl

Overview:
Parametrised data memory for the CPU load/store path. It replaces the shared tristate data bus with separate write-data and read-data buses and a valid/ready request port plus a response port. It supports byte, halfword and word accesses with sign/zero extension, a configurable read latency and misalignment/range error reporting. An optional hardware clear sequence zeroes the array after reset.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32 (the byte-lane logic assumes 4 lanes)
- DEPTH, 1024, number of words; must be a power of two
- ADDR_WIDTH, 32, byte-address width
- READ_LATENCY, 1, cycles from read acceptance to rsp_valid; legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero the whole array word-by-word after reset; 0 = no clear (contents undefined)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid; request was misaligned, out of range or of illegal size
- init_done  out  1  high once the clear sequence has finished; stays high until the next reset

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, clear counter=0, FSM=CLEAR if CLEAR_ON_RESET else IDLE. Array contents are not reset asynchronously.
- FSM states are CLEAR, IDLE, RDWAIT and RESP.
- CLEAR:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - On cnt==DEPTH-1 the FSM moves to IDLE and init_done rises in the same edge. Total duration is DEPTH cycles.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1. A handshake is req_valid & req_ready at a rising edge.
  - Word index = req_addr[log2(DEPTH)+1:2]. Byte lane = req_addr[1:0].
  - The request has an error if any of these hold:
    - size==11
    - half with addr[0]=1
    - word with addr[1:0]!=0
    - req_addr[ADDR_WIDTH-1:log2(DEPTH)+2] is nonzero
  - Accepted store: bytes are written in the handshake edge using per-lane enables (byte: 1 lane; half: lanes {1,0} or {3,2}; word: all). Other lanes are unchanged. Next state is RESP.
  - Accepted load: the word is captured into a pipeline and a counter is loaded with READ_LATENCY-1. Next state is RESP if READ_LATENCY==1, else RDWAIT.
  - An erroring request never writes the array. It goes to RESP after the same latency its type would normally take.
- RDWAIT: req_ready=0. The counter decrements each cycle; at 1 the FSM moves to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_err and rsp_rdata valid. req_ready=0.
  - Next state is IDLE.
  - Load result: the selected lane is shifted to bit 0, then sign- or zero-extended according to req_unsigned (latched at acceptance).
- Latency from the handshake edge to the rsp_valid cycle:
  - store: 1 cycle
  - load: READ_LATENCY cycles
  - Minimum issue interval: store 2 cycles; load READ_LATENCY+1 cycles.
- Only one request is outstanding at a time. rsp_valid has no backpressure.
- req_valid while req_ready=0 is ignored; the requester must hold it until accepted.
- Request fields are latched at acceptance, so input changes after acceptance have no effect.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending response is dropped. An in-flight store either completed at its accept edge or not at all.
- Data consistency: a load issued immediately after a store to the same word returns the new data.

Decomposition:
- Shared package / defines file:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state encodings
  - CPU_WIDTH and RAM_DEPTH, used as the parameter defaults
- Sub-module ram_bytewe_array: a synchronous, byte-enabled, single-port storage array with registered read output. The controller FSM, lane select, extension and error logic stay in data_ram_ctrl.

Test Plan:
- Clear sequence: reset with DEPTH=16 → req_ready=0 for 16 cycles, then init_done=1 and req_ready=1; a word load from 0x3C returns 0x00000000.
- Byte store and signed/unsigned loads:
  - SW 0x11223344 to 0x8, then SB 0x80 to 0x9.
  - LW 0x8 → 0x11228044.
  - LB 0x9 → 0xFFFFFF80.
  - LBU 0x9 → 0x00000080.
- Half access: SH 0xBEEF to 0xE, then LH 0xE → 0xFFFFBEEF and LHU 0xE → 0x0000BEEF; LW 0xC shows only the upper half changed.
- Errors:
  - LH 0x5 → rsp_err=1, rdata=0.
  - SW 0x6 → rsp_err=1 and the word is unchanged.
  - size=11 → rsp_err=1.
  - Address DEPTH*4 → rsp_err=1.
- Latency sweep over READ_LATENCY=1,2,4: rsp_valid arrives exactly N cycles after the load handshake; req_ready=0 in between; back-to-back requests each get one response.
- Reset mid-read (READ_LATENCY=3, rst_n low at the 2nd cycle) → no rsp_valid after release; the clear sequence restarts and init_done=0 until it completes.

Source files
------------

// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: shared encodings, default sizes and lane-mask helper for the data RAM controller
package data_ram_ctrl_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int RAM_DEPTH = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RDWAIT,
        ST_RESP
    } state_e;

    // Byte-lane write enables for an access of the given size starting at the given lane
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        lane_mask = (size == SZ_BYTE) ? (4'b0001 << lane) :
                    (size == SZ_HALF) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_array.sv
// ram_bytewe_array: single-port word array with per-byte write enables and a registered read port
module ram_bytewe_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [IDX_WIDTH-1:0]    i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    assign o_rdata = r_rdata;

    // Byte-lane writes and a registered read of the addressed word; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        r_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: valid/ready load/store front end for a byte-enabled data RAM with post-reset clear
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = CPU_WIDTH,
    parameter int DEPTH          = RAM_DEPTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_init_done
);

    localparam int IW = $clog2(DEPTH);

    state_e          r_state;
    logic [IW-1:0]   r_cnt;
    logic [1:0]      r_lat;
    logic [IW-1:0]   r_word;
    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_uns;
    logic            r_we;
    logic            r_err;
    logic            r_ready;
    logic            r_rsp_valid;
    logic            r_init_done;

    logic [IW-1:0]           w_word;
    logic [1:0]              w_lane;
    logic                    w_err;
    logic                    w_hs;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [IW-1:0]           w_ram_addr;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;
    logic [DATA_WIDTH-1:0]   w_shift;
    logic [DATA_WIDTH-1:0]   w_ext;

    assign w_word = i_req_addr[IW+1:2];
    assign w_lane = i_req_addr[1:0];
    assign w_hs   = i_req_valid & r_ready;

    // Illegal size, misaligned half/word, or any address bit above the array range
    assign w_err = (i_req_size == SZ_ILL) |
                   ((i_req_size == SZ_HALF) & i_req_addr[0]) |
                   ((i_req_size == SZ_WORD) & (i_req_addr[1:0] != 2'b00)) |
                   (|(i_req_addr >> (IW + 2)));

    // The clear sequence owns the array port; otherwise only a clean accepted store writes it
    assign w_be = (r_state == ST_CLEAR) ? 4'b1111 :
                  (w_hs & i_req_we & ~w_err) ? lane_mask(i_req_size, w_lane) : 4'b0000;

    // Right-aligned store data is replicated across lanes so the enables pick the right copy
    assign w_wdata = (r_state == ST_CLEAR) ? '0 :
                     (i_req_size == SZ_BYTE) ? {(DATA_WIDTH/8){i_req_wdata[7:0]}} :
                     (i_req_size == SZ_HALF) ? {(DATA_WIDTH/16){i_req_wdata[15:0]}} : i_req_wdata;

    // While idle the array reads the offered word so a 1-cycle load has data by the response cycle
    assign w_ram_addr = (r_state == ST_CLEAR) ? r_cnt :
                        (r_state == ST_IDLE)  ? w_word : r_word;

    ram_bytewe_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IW)
    ) u_array (
        .clk    (clk),
        .i_be   (w_be),
        .i_addr (w_ram_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_ram_rdata)
    );

    assign w_shift = w_ram_rdata >> {r_lane, 3'b000};
    assign w_ext   = (r_size == SZ_BYTE) ? {{(DATA_WIDTH-8){~r_uns & w_shift[7]}}, w_shift[7:0]} :
                     (r_size == SZ_HALF) ? {{(DATA_WIDTH-16){~r_uns & w_shift[15]}}, w_shift[15:0]} : w_shift;

    assign o_req_ready = r_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_valid & r_err;
    assign o_rsp_rdata = (r_rsp_valid & ~r_we & ~r_err) ? w_ext : '0;
    assign o_init_done = r_init_done;

    // Controller FSM: clear sweep, request acceptance, read-latency wait and one-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt       <= '0;
            r_lat       <= '0;
            r_word      <= '0;
            r_lane      <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IW'(DEPTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                    if (w_hs) begin
                        r_ready <= 1'b0;
                        r_word  <= w_word;
                        r_lane  <= w_lane;
                        r_size  <= i_req_size;
                        r_uns   <= i_req_unsigned;
                        r_we    <= i_req_we;
                        r_err   <= w_err;
                        r_lat   <= 2'(READ_LATENCY - 1);
                        if (i_req_we || READ_LATENCY == 1) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    r_lat <= r_lat - 1'b1;
                    if (r_lat == 2'd1) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed checks of data_ram_ctrl at read latencies 1..4 with a 16-word array
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n   [4];
    logic        valid   [4];
    logic        we      [4];
    logic        uns     [4];
    logic [31:0] addr    [4];
    logic [31:0] wdata   [4];
    logic [1:0]  size    [4];
    logic        ready   [4];
    logic        rv      [4];
    logic        err     [4];
    logic        idone   [4];
    logic [31:0] rdata   [4];
    int          rsp_cnt [4] = '{default: 0};
    int          req_cnt [4] = '{default: 0};
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_ram_ctrl #(
            .DATA_WIDTH    (32),
            .DEPTH         (16),
            .ADDR_WIDTH    (32),
            .READ_LATENCY  (g + 1),
            .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .i_req_valid   (valid[g]),
            .o_req_ready   (ready[g]),
            .i_req_we      (we[g]),
            .i_req_addr    (addr[g]),
            .i_req_size    (size[g]),
            .i_req_unsigned(uns[g]),
            .i_req_wdata   (wdata[g]),
            .o_rsp_valid   (rv[g]),
            .o_rsp_rdata   (rdata[g]),
            .o_rsp_err     (err[g]),
            .o_init_done   (idone[g])
        );
    end

    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (rv[i]) rsp_cnt[i]++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where the response is visible
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat, output logic rdy_ok);
        int n;
        valid[k] = 1'b1; we[k] = w; addr[k] = a; size[k] = s; uns[k] = u; wdata[k] = d;
        n = 0;
        while (!ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        rd = '0; e = 1'b0; lat = -1; rdy_ok = 1'b0;
        if (!ready[k]) begin
            total++; bad++;
            $error("FAIL accept_timeout inst=%0d observed=not_ready expected=ready", k);
            valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        req_cnt[k]++;
        @(negedge clk);
        valid[k] = 1'b0; addr[k] = 32'hFFFF_FFFF; size[k] = 2'b11; wdata[k] = 32'h0; uns[k] = ~u; we[k] = ~w;
        lat = 1; rdy_ok = 1'b1;
        while (!rv[k] && lat < 20) begin
            if (ready[k]) rdy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!rv[k]) lat = -1;
        rd = rdata[k];
        e = err[k];
    endtask

    task automatic op(input int k, input string tag, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic u, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic        rdy_ok;
        xfer(k, w, a, s, u, d, rd, e, lat, rdy_ok);
        chk({tag, "_data"}, rd, exp_d);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdy_low"}, {31'b0, rdy_ok}, 32'd1);
    endtask

    // Called on the falling edge where reset is released
    task automatic clear_wait(input int k, input string tag);
        int n;
        n = 0;
        while (!ready[k] && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_clear_cycles"}, 32'(n), 32'd16);
        chk({tag, "_init_done"}, {31'b0, idone[k]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before test end");
        $fatal(1);
    end

    initial begin
        int saved;
        for (int i = 0; i < 4; i++) begin
            rst_n[i] = 1'b0; valid[i] = 1'b0; we[i] = 1'b0; uns[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0; size[i] = 2'b10;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready[0]}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rv[0]}, 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_err", {31'b0, err[0]}, 32'd0);
        chk("rst_init_done", {31'b0, idone[0]}, 32'd0);
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        clear_wait(0, "boot");

        op(0, "lw_3c",   1'b0, 32'h3C, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1);
        op(0, "sw_8",    1'b1, 32'h08, 2'b10, 1'b0, 32'h1122_3344, 32'h0000_0000, 1'b0, 1);
        op(0, "sb_9",    1'b1, 32'h09, 2'b00, 1'b0, 32'hAAAA_AA80, 32'h0000_0000, 1'b0, 1);
        op(0, "lw_8",    1'b0, 32'h08, 2'b10, 1'b0, 32'h0,         32'h1122_8044, 1'b0, 1);
        op(0, "lb_9",    1'b0, 32'h09, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 1);
        op(0, "lbu_9",   1'b0, 32'h09, 2'b00, 1'b1, 32'h0,         32'h0000_0080, 1'b0, 1);
        op(0, "lb_b",    1'b0, 32'h0B, 2'b00, 1'b0, 32'h0,         32'h0000_0011, 1'b0, 1);
        op(0, "sw_c",    1'b1, 32'h0C, 2'b10, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0, 1);
        op(0, "sh_e",    1'b1, 32'h0E, 2'b01, 1'b0, 32'h7777_BEEF, 32'h0000_0000, 1'b0, 1);
        op(0, "lh_e",    1'b0, 32'h0E, 2'b01, 1'b0, 32'h0,         32'hFFFF_BEEF, 1'b0, 1);
        op(0, "lhu_e",   1'b0, 32'h0E, 2'b01, 1'b1, 32'h0,         32'h0000_BEEF, 1'b0, 1);
        op(0, "lh_c",    1'b0, 32'h0C, 2'b01, 1'b0, 32'h0,         32'h0000_5678, 1'b0, 1);
        op(0, "lw_c",    1'b0, 32'h0C, 2'b10, 1'b0, 32'h0,         32'hBEEF_5678, 1'b0, 1);

        op(0, "lh_5",    1'b0, 32'h05, 2'b01, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1);
        op(0, "sw_6",    1'b1, 32'h06, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1);
        op(0, "lw_4",    1'b0, 32'h04, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1);
        op(0, "ill_8",   1'b0, 32'h08, 2'b11, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1);
        op(0, "lw_40",   1'b0, 32'h40, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1);
        op(0, "sw_40",   1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 1);
        op(0, "lw_0",    1'b0, 32'h00, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1);
        op(0, "lw_8b",   1'b0, 32'h08, 2'b10, 1'b0, 32'h0,         32'h1122_8044, 1'b0, 1);

        for (int k = 1; k < 4; k++) begin
            op(k, $sformatf("sw_rl%0d", k + 1), 1'b1, 32'h10, 2'b10, 1'b0, 32'hA5A5_5A5A, 32'h0, 1'b0, 1);
            op(k, $sformatf("lw_rl%0d", k + 1), 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hA5A5_5A5A, 1'b0, k + 1);
            op(k, $sformatf("lb_rl%0d", k + 1), 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b0, k + 1);
            op(k, $sformatf("lherr_rl%0d", k + 1), 1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, k + 1);
            op(k, $sformatf("swerr_rl%0d", k + 1), 1'b1, 32'h12, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        end

        @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rsp_count_rl%0d", k + 1), 32'(rsp_cnt[k]), 32'(req_cnt[k]));

        valid[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h10; size[2] = 2'b10; uns[2] = 1'b0;
        for (int n = 0; n < 10 && !ready[2]; n++) @(negedge clk);
        chk("mid_rst_ready", {31'b0, ready[2]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid[2] = 1'b0;
        @(negedge clk);
        saved = rsp_cnt[2];
        rst_n[2] = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rv[2]}, 32'd0);
        chk("mid_rst_init_done", {31'b0, idone[2]}, 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        chk("mid_rst_release_init", {31'b0, idone[2]}, 32'd0);
        clear_wait(2, "mid_rst");
        repeat (3) @(negedge clk);
        chk("mid_rst_no_rsp", 32'(rsp_cnt[2]), 32'(saved));
        op(2, "lw_after_rst", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
